// File: rtl/rtz_pkg.sv
// Shared constants and the default-width round-toward-zero split used by
// rtz-family rounders and by bench reference models.
package rtz_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DROP_DEF   = 2;

  // Quantized value and the residual that was discarded to reach it.
  typedef struct packed {
    logic signed [DATA_W_DEF-1:0] q;
    logic signed [DROP_DEF:0]     r;
  } rtz_split_t;

  // Truncate toward zero at bit DROP_DEF; r = x - q carries the sign of x.
  function automatic rtz_split_t rtz_split(input logic signed [DATA_W_DEF-1:0] x);
    rtz_split_t           res;
    logic [DROP_DEF-1:0]  low;
    logic                 neg_frac;
    low      = x[DROP_DEF-1:0];
    neg_frac = x[DATA_W_DEF-1] && (low != '0);
    res.q    = {x[DATA_W_DEF-1:DROP_DEF], {DROP_DEF{1'b0}}};
    res.r    = {1'b0, low};
    if (neg_frac) begin
      res.q = res.q + DATA_W_DEF'(1 << DROP_DEF);
      res.r = res.r - (DROP_DEF+1)'(1 << DROP_DEF);
    end
    return res;
  endfunction

endpackage

// File: rtl/rtz_quant.sv
// Combinational round-toward-zero quantizer: splits a signed sample into the
// truncated value q (multiple of 2^DROP) and the residual r = in_data - q.
module rtz_quant
  import rtz_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DROP   = DROP_DEF
) (
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] q,
  output logic [DROP:0]     r
);

  logic [DROP-1:0] low;
  logic            neg_frac;

  assign low      = in_data[DROP-1:0];
  // A negative sample with discarded bits must move up by one step so the
  // truncation heads toward zero instead of toward minus infinity.
  assign neg_frac = in_data[DATA_W-1] && (low != '0);

  // Split the sample; the residual is formed at narrow width from the low bits.
  always_comb begin
    q = {in_data[DATA_W-1:DROP], {DROP{1'b0}}};
    r = {1'b0, low};
    if (neg_frac) begin
      q = q + DATA_W'(1 << DROP);
      r = r - (DROP+1)'(1 << DROP);
    end
  end

endmodule

// File: rtl/rtz_err_comp.sv
// Streaming round-toward-zero quantizer with first-order error diffusion.
// Handshake: a transfer happens on a cycle where valid && ready are both high
// at the rising edge; valid never depends on ready, and once out_valid rises
// out_data/out_last stay stable until the cycle out_ready is sampled high.
module rtz_err_comp
  import rtz_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DROP   = DROP_DEF,
  parameter int ACC_W  = DROP + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              sat_flag
);

  localparam logic signed [ACC_W-1:0] STEP_A  = ACC_W'(1 << DROP);
  localparam logic signed [ACC_W-1:0] NSTEP_A = -STEP_A;
  localparam logic signed [ACC_W-1:0] AMAX    = STEP_A - ACC_W'(1);
  localparam logic signed [ACC_W-1:0] AMIN    = -AMAX;
  localparam logic signed [DATA_W:0]  STEP_Y  = (DATA_W+1)'(1 << DROP);
  localparam logic signed [DATA_W:0]  YMAX    = (DATA_W+1)'((1 << (DATA_W-1)) - (1 << DROP));
  localparam logic signed [DATA_W:0]  YMIN    = -((DATA_W+1)'(1 << (DATA_W-1)));

  logic [DATA_W-1:0]        q;
  logic [DROP:0]            r;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  r_ext;
  logic signed [ACC_W-1:0]  t;
  logic signed [ACC_W-1:0]  acc_n;
  logic signed [DATA_W:0]   y;
  logic signed [DATA_W:0]   y_sat;
  logic                     sat;
  logic                     accept;

  rtz_quant #(
    .DATA_W (DATA_W),
    .DROP   (DROP)
  ) u_quant (
    .in_data (in_data),
    .q       (q),
    .r       (r)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign r_ext    = {{(ACC_W-DROP-1){r[DROP]}}, r};
  assign t        = acc + r_ext;

  // Fold a whole output step out of the residual, then clamp on saturation.
  always_comb begin
    y     = {q[DATA_W-1], q};
    acc_n = t;
    sat   = 1'b0;
    if (t >= STEP_A) begin
      y     = y + STEP_Y;
      acc_n = t - STEP_A;
    end else if (t <= NSTEP_A) begin
      y     = y - STEP_Y;
      acc_n = t + STEP_A;
    end
    y_sat = y;
    if (y > YMAX || y < YMIN) begin
      // The correction could not be emitted, so the residual keeps as much
      // of it as its magnitude bound allows.
      sat   = 1'b1;
      y_sat = (y > YMAX) ? YMAX : YMIN;
      if (t > AMAX) begin
        acc_n = AMAX;
      end else if (t < AMIN) begin
        acc_n = AMIN;
      end else begin
        acc_n = t;
      end
    end
  end

  // Output register, residual accumulator and sticky saturation flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      sat_flag  <= 1'b0;
      acc       <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= y_sat[DATA_W-1:0];
      out_last  <= in_last;
      sat_flag  <= sat_flag | sat;
      acc       <= in_last ? '0 : acc_n;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rtz_err_comp.sv
// Directed bench for rtz_err_comp with hand-computed expectations.
module tb_rtz_err_comp;
  import rtz_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_last;
  logic               sat_flag;

  int n_checks = 0;
  int n_fail   = 0;
  int out_sum  = 0;

  rtz_err_comp dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .sat_flag  (sat_flag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Present one sample for one cycle (in_ready is expected high), then check
  // the registered result #1 after the edge.
  task automatic push(input int d, input logic last, input int exp_y, input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 1);
    in_valid = 1'b1;
    in_data  = 16'(d);
    in_last  = last;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_data"}, 32'(out_data), 32'(exp_y));
    chk({tag, "_last"}, 32'(out_last), 32'(last));
    out_sum += int'(out_data);
  endtask

  rtz_split_t sp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;

    // Package split function against the documented examples.
    sp = rtz_split(-16'sd7); chk("split_m7_q", 32'(sp.q), -4); chk("split_m7_r", 32'(sp.r), -3);
    sp = rtz_split(-16'sd8); chk("split_m8_q", 32'(sp.q), -8);
    sp = rtz_split(-16'sd3); chk("split_m3_q", 32'(sp.q), 0);
    sp = rtz_split(16'sd7);  chk("split_7_q", 32'(sp.q), 4);  chk("split_7_r", 32'(sp.r), 3);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_sat", 32'(sat_flag), 0);
    chk("rst_acc", 32'(dut.acc), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Residual build-up 5,5,5,5 -> 4,4,4,8
    out_sum = 0;
    push(5, 1'b0, 4, "bu0");
    push(5, 1'b0, 4, "bu1");
    push(5, 1'b0, 4, "bu2");
    push(5, 1'b1, 8, "bu3");
    chk("bu_acc", 32'(dut.acc), 0);
    chk("bu_sum", 32'(out_sum), 20);

    // Negative residuals
    push(-7, 1'b0, -4, "neg0");
    chk("neg0_acc", 32'(dut.acc), -3);
    push(-7, 1'b0, -8, "neg1");
    chk("neg1_acc", 32'(dut.acc), -2);
    push(0, 1'b1, 0, "negflush");
    chk("negflush_acc", 32'(dut.acc), 0);
    push(-3, 1'b0, 0, "m3");
    chk("m3_acc", 32'(dut.acc), -3);
    push(0, 1'b1, 0, "m3flush");

    // Flush versus carry-over
    push(7, 1'b1, 4, "fl0");
    chk("fl0_acc", 32'(dut.acc), 0);
    push(7, 1'b0, 4, "fl1");
    chk("fl1_acc", 32'(dut.acc), 3);
    push(0, 1'b1, 0, "fl_clr");
    push(7, 1'b0, 4, "nf0");
    push(7, 1'b0, 8, "nf1");
    chk("nf1_acc", 32'(dut.acc), 2);
    push(0, 1'b1, 0, "nf_clr");
    chk("nf_clr_acc", 32'(dut.acc), 0);

    // Saturation
    push(16'sh0003, 1'b0, 0, "sat0");
    chk("sat0_flag", 32'(sat_flag), 0);
    push(16'sh7FFF, 1'b0, 16'sh7FFC, "sat1");
    chk("sat1_flag", 32'(sat_flag), 1);
    chk("sat1_acc", 32'(dut.acc), 3);
    push(16'sh0001, 1'b0, 4, "sat2");
    chk("sat2_acc", 32'(dut.acc), 0);
    chk("sat2_flag", 32'(sat_flag), 1);

    // Drain, then backpressure: first sample accepted, second must wait
    @(posedge clk);
    #1;
    chk("drain_valid", 32'(out_valid), 0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'sd5;
    @(posedge clk);
    #1;
    chk("bp_first_valid", 32'(out_valid), 1);
    chk("bp_first_data", 32'(out_data), 4);
    in_data = 16'sd9;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("bp_hold_data", 32'(out_data), 4);
      chk("bp_hold_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_acc", 32'(dut.acc), 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("bp_rel_data", 32'(out_data), 8);
    chk("bp_rel_valid", 32'(out_valid), 1);
    chk("bp_rel_acc", 32'(dut.acc), 2);

    // Reset mid-stream while holding a result and acc=2
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_data", 32'(out_data), 0);
    chk("mrst_acc", 32'(dut.acc), 0);
    chk("mrst_sat", 32'(sat_flag), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(5, 1'b0, 4, "post_mrst");
    @(posedge clk);
    #1;
    chk("post_mrst_no_dup", 32'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
